// File: rtl/alu_issue.sv
// Issue/writeback controller for the 2-stage pipelined integer ALU: RAW hazard
// bubbles, operand resolution and aligned writeback. Define ALU_ISSUE_FORWARD_EN
// to forward the ALU result register instead of stalling on stage-2 hazards.
module alu_issue #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned PC_W       = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned OP_W       = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [PC_W-1:0]       in_pc,
  input  logic [OP_W-1:0]       in_instruction,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_writes_rd,
  output logic [REG_ADDR_W-1:0] rf_raddr1,
  output logic [REG_ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0]     rf_rdata1,
  input  logic [DATA_W-1:0]     rf_rdata2,
  output logic                  alu_enable,
  output logic [PC_W-1:0]       alu_pc,
  output logic [OP_W-1:0]       alu_instruction,
  output logic [DATA_W-1:0]     alu_op1,
  output logic [DATA_W-1:0]     alu_op2,
  output logic [DATA_W-1:0]     alu_imm,
  input  logic [DATA_W-1:0]     alu_result,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic [CNT_W-1:0]      issue_count,
  output logic [CNT_W-1:0]      bubble_count
);

  localparam logic [OP_W-1:0] ALU_NOP = '0;

  logic                  r_t1_valid, r_t1_writes;
  logic [REG_ADDR_W-1:0] r_t1_rd;
  logic                  r_t2_valid, r_t2_writes;
  logic [REG_ADDR_W-1:0] r_t2_rd;
  logic [CNT_W-1:0]      r_issue_count, r_bubble_count;

  logic w_t1_hz1, w_t1_hz2, w_t2_hz1, w_t2_hz2;
  logic w_stall_hz, w_ready, w_accept;
  logic [DATA_W-1:0] w_op1, w_op2;

  function automatic logic hz(input logic v, input logic w,
                              input logic [REG_ADDR_W-1:0] rd,
                              input logic [REG_ADDR_W-1:0] rs);
    return v && w && (rd == rs) && (rs != '0);
  endfunction

  always_comb begin
    w_t1_hz1 = hz(r_t1_valid, r_t1_writes, r_t1_rd, in_rs1);
    w_t1_hz2 = hz(r_t1_valid, r_t1_writes, r_t1_rd, in_rs2);
    w_t2_hz1 = hz(r_t2_valid, r_t2_writes, r_t2_rd, in_rs1);
    w_t2_hz2 = hz(r_t2_valid, r_t2_writes, r_t2_rd, in_rs2);
`ifdef ALU_ISSUE_FORWARD_EN
    w_stall_hz = w_t1_hz1 | w_t1_hz2;
`else
    w_stall_hz = w_t1_hz1 | w_t1_hz2 | w_t2_hz1 | w_t2_hz2;
`endif
    w_ready  = !rst && !stall && !w_stall_hz;
    w_accept = in_valid && w_ready;
  end

  // Operand resolution: x0 reads zero; a stage-2 producer is taken from the ALU result when forwarding.
  always_comb begin
    w_op1 = (in_rs1 == '0) ? '0 : rf_rdata1;
    w_op2 = (in_rs2 == '0) ? '0 : rf_rdata2;
`ifdef ALU_ISSUE_FORWARD_EN
    if (w_t2_hz1) w_op1 = alu_result;
    if (w_t2_hz2) w_op2 = alu_result;
`endif
  end

  always_comb begin
    in_ready        = w_ready;
    rf_raddr1       = in_rs1;
    rf_raddr2       = in_rs2;
    alu_enable      = !stall && !rst;
    alu_pc          = w_accept ? in_pc : '0;
    alu_instruction = w_accept ? in_instruction : ALU_NOP;
    alu_op1         = w_accept ? w_op1 : '0;
    alu_op2         = w_accept ? w_op2 : '0;
    alu_imm         = w_accept ? in_imm : '0;
    wb_valid        = r_t2_valid && r_t2_writes && (r_t2_rd != '0) && !stall && !rst;
    wb_rd           = r_t2_rd;
    wb_data         = alu_result;
    issue_count     = r_issue_count;
    bubble_count    = r_bubble_count;
  end

  // Tag pipe mirrors the ALU stages and freezes with them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_t1_valid  <= 1'b0;
      r_t1_writes <= 1'b0;
      r_t1_rd     <= '0;
      r_t2_valid  <= 1'b0;
      r_t2_writes <= 1'b0;
      r_t2_rd     <= '0;
    end else if (!stall) begin
      r_t2_valid  <= r_t1_valid;
      r_t2_writes <= r_t1_writes;
      r_t2_rd     <= r_t1_rd;
      r_t1_valid  <= w_accept;
      r_t1_writes <= in_writes_rd;
      r_t1_rd     <= in_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_accept) r_issue_count <= r_issue_count + CNT_W'(1);
      if (!stall && in_valid && !w_ready) r_bubble_count <= r_bubble_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: sequential-semantics register model plus an
// in-flight age list predict readiness, operands, writebacks and counters.
module tb_alu_issue;
  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_ADDI = 4'd2,
                         OP_SUB = 4'd3, OP_XOR = 4'd4;
`ifdef ALU_ISSUE_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, rst, stall, in_valid, in_ready, in_writes_rd;
  logic [31:0] in_pc, in_imm;
  logic [3:0]  in_instruction;
  logic [4:0]  in_rs1, in_rs2, in_rd, rf_raddr1, rf_raddr2, wb_rd;
  logic [31:0] rf_rdata1, rf_rdata2, alu_pc, alu_op1, alu_op2, alu_imm, alu_result, wb_data;
  logic [3:0]  alu_instruction;
  logic        alu_enable, wb_valid;
  logic [31:0] issue_count, bubble_count;

  alu_issue dut (
    .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instruction(in_instruction), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_imm(in_imm), .in_writes_rd(in_writes_rd),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_enable(alu_enable), .alu_pc(alu_pc), .alu_instruction(alu_instruction),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_imm(alu_imm), .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .issue_count(issue_count), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] imm);
    case (op)
      OP_ADD:  return a + b;
      OP_ADDI: return a + imm;
      OP_SUB:  return a - b;
      OP_XOR:  return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // Environment: register file and two-stage ALU driven by the DUT.
  logic [31:0] rf [32];
  logic [3:0]  s1_op;
  logic [31:0] s1_a, s1_b, s1_imm, r_res;
  assign rf_rdata1  = rf[rf_raddr1];
  assign rf_rdata2  = rf[rf_raddr2];
  assign alu_result = r_res;
  always @(posedge clk) begin
    if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
    if (alu_enable) begin
      r_res  <= alu_f(s1_op, s1_a, s1_b, s1_imm);
      s1_op  <= alu_instruction;
      s1_a   <= alu_op1;
      s1_b   <= alu_op2;
      s1_imm <= alu_imm;
    end
  end

  // Reference model
  typedef struct {logic [4:0] rd; bit wr; logic [31:0] val; int age;} fl_t;
  fl_t         fq[$];
  logic [31:0] arch [32];
  logic [31:0] exp_issue, exp_bubble;
  int          total, bad, n_wb4;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit blocked(input logic [4:0] rs);
    foreach (fq[i])
      if (rs != 5'd0 && fq[i].wr && fq[i].rd == rs && (fq[i].age == 1 || (fq[i].age == 2 && !FWD)))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(output bit acc);
    bit er, ewb;
    logic [4:0] wrd;
    logic [31:0] wdat, a, b, v;
    fl_t nq[$];
    fl_t e;
    @(negedge clk);
    er  = !rst && !stall && !blocked(in_rs1) && !blocked(in_rs2);
    acc = in_valid && er;
    ewb = 1'b0; wrd = '0; wdat = '0;
    if (!rst && !stall)
      foreach (fq[i])
        if (fq[i].age == 2 && fq[i].wr && fq[i].rd != 5'd0) begin
          ewb = 1'b1; wrd = fq[i].rd; wdat = fq[i].val;
        end
    chk("in_ready", in_ready, er);
    chk("alu_enable", alu_enable, !rst && !stall);
    chk("wb_valid", wb_valid, ewb);
    if (ewb) begin
      chk("wb_rd", wb_rd, wrd);
      chk("wb_data", wb_data, wdat);
    end
    if (wb_valid && wb_rd == 5'd4) n_wb4++;
    chk("issue_count", issue_count, exp_issue);
    chk("bubble_count", bubble_count, exp_bubble);
    a = (in_rs1 == 5'd0) ? 32'd0 : arch[in_rs1];
    b = (in_rs2 == 5'd0) ? 32'd0 : arch[in_rs2];
    if (acc) begin
      chk("alu_instr", alu_instruction, in_instruction);
      chk("alu_ops", {alu_op1, alu_op2}, {a, b});
      chk("alu_pc_imm", {alu_pc, alu_imm}, {in_pc, in_imm});
    end else begin
      chk("bubble_instr", alu_instruction, OP_NOP);
      chk("bubble_fields", {alu_pc, alu_op1 | alu_op2 | alu_imm}, 64'd0);
    end
    if (rst) begin
      fq.delete();
      exp_issue = 0; exp_bubble = 0;
      foreach (arch[i]) arch[i] = rf[i];
    end else if (!stall) begin
      foreach (fq[i]) begin
        e = fq[i]; e.age++;
        if (e.age <= 2) nq.push_back(e);
      end
      fq = nq;
      if (acc) begin
        v = alu_f(in_instruction, a, b, in_imm);
        fq.push_back('{in_rd, in_writes_rd, v, 1});
        if (in_writes_rd && in_rd != 5'd0) arch[in_rd] = v;
        exp_issue++;
      end
      if (in_valid && !er) exp_bubble++;
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_instruction = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm = imm; in_writes_rd = 1'b1; in_pc = $urandom;
    for (int k = 0; k < 20 && !acc; k++) step(acc);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] b0, r7, r9;
    bit acc;
    total = 0; bad = 0; n_wb4 = 0;
    rst = 1'b1; stall = 1'b0; in_valid = 1'b0; in_pc = '0; in_instruction = OP_NOP;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0; in_writes_rd = 1'b0;
    s1_op = OP_NOP; s1_a = '0; s1_b = '0; s1_imm = '0; r_res = '0;
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
    exp_issue = 0; exp_bubble = 0;
    @(posedge clk); #1;
    idle(1);
    rst = 1'b0;

    // Single ADDI: issue, 2-cycle writeback
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    idle(3);
    chk("t1_issue", issue_count, 1);
    chk("t1_x1", rf[1], 5);

    // Back-to-back dependency
    b0 = bubble_count;
    send(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
    send(OP_ADD, 5'd2, 5'd1, 5'd1, 32'd0);
    idle(3);
    chk("t2_bubbles", bubble_count - b0, FWD ? 1 : 2);
    chk("t2_x2", rf[2], 10);

    // Dependencies through x0 never stall
    b0 = bubble_count;
    send(OP_ADDI, 5'd0, 5'd0, 5'd0, 32'd7);
    send(OP_ADD, 5'd3, 5'd0, 5'd0, 32'd0);
    idle(3);
    chk("t3_bubbles", bubble_count - b0, 0);
    chk("t3_x3", rf[3], 0);
    chk("t3_x0", rf[0], 0);

    // Stall held while the result sits in stage 2
    send(OP_ADDI, 5'd5, 5'd0, 5'd0, 32'd4);
    send(OP_ADDI, 5'd6, 5'd0, 5'd0, 32'd5);
    idle(3);
    n_wb4 = 0;
    send(OP_ADD, 5'd4, 5'd5, 5'd6, 32'd0);
    idle(1);
    stall = 1'b1;
    idle(3);
    stall = 1'b0;
    idle(3);
    chk("t4_wb_once", n_wb4, 1);
    chk("t4_x4", rf[4], 9);

    // Reset with two writes in flight
    r7 = rf[7]; r9 = rf[9];
    send(OP_ADDI, 5'd7, 5'd0, 5'd0, r7 + 32'd11);
    send(OP_ADDI, 5'd9, 5'd0, 5'd0, r9 + 32'd12);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_issue0", issue_count, 0);
    chk("t5_bubble0", bubble_count, 0);
    idle(3);
    chk("t5_x7", rf[7], r7);
    chk("t5_x9", rf[9], r9);

    // 100 independent instructions streamed
    b0 = bubble_count;
    r7 = issue_count;
    for (int k = 0; k < 100; k++)
      send(OP_ADDI, 5'(8 + k % 24), 5'd0, 5'd0, 32'(k));
    idle(3);
    chk("t6_issue", issue_count - r7, 100);
    chk("t6_bubbles", bubble_count - b0, 0);

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      rst            = ($urandom_range(0, 199) == 0);
      stall          = ($urandom_range(0, 9) == 0);
      in_valid       = ($urandom_range(0, 9) < 7);
      in_instruction = 4'($urandom_range(1, 4));
      in_rd          = 5'($urandom_range(0, 7));
      in_rs1         = 5'($urandom_range(0, 7));
      in_rs2         = 5'($urandom_range(0, 7));
      in_imm         = 32'($urandom_range(0, 255));
      in_writes_rd   = ($urandom_range(0, 5) != 0);
      in_pc          = $urandom;
      step(acc);
    end
    rst = 1'b0; stall = 1'b0;
    idle(4);
    chk("drain", fq.size(), 0);
    for (int i = 0; i < 32; i++) chk("final_rf", rf[i], arch[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
